// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: issues one instruction-memory read at a time,
// holds the returned word for the IF/ID register, and follows redirects.
//
// Memory handshake: a request is accepted on a clock edge where im_req and
// im_ready are both 1. Exactly one response (im_rvalid=1 for one cycle) comes
// back per accepted request, in order, possibly in the same cycle as im_ready.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IFID_write,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ready,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        if_valid,
  output logic        IFID_flush,
  output logic [1:0]  fsm_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]  state, state_n;
  logic [31:0] fetch_pc, fetch_pc_n;
  logic [31:0] instr_q, instr_n;
  logic        drop, drop_n;
  logic [31:0] redir_target;

  // Redirect targets are always word aligned.
  assign redir_target = redirect_pc & 32'hFFFF_FFFC;

  // Next-state, next fetch PC, capture data and drop-flag decisions.
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    instr_n    = instr_q;
    drop_n     = drop;
    case (state)
      S_IDLE: begin
        state_n = S_REQ;
        if (redirect_valid) fetch_pc_n = redir_target;
      end
      S_REQ: begin
        if (redirect_valid) begin
          fetch_pc_n = redir_target;
          // Accepted together with a redirect: its response is wrong-path.
          // If that response is already here it is simply ignored.
          if (im_ready && !im_rvalid) begin
            state_n = S_WAIT;
            drop_n  = 1'b1;
          end
        end else if (im_ready) begin
          if (im_rvalid) begin
            instr_n = im_rdata;
            state_n = S_HOLD;
          end else begin
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          fetch_pc_n = redir_target;
          if (im_rvalid) begin
            state_n = S_REQ;
            drop_n  = 1'b0;
          end else begin
            drop_n  = 1'b1;
          end
        end else if (im_rvalid) begin
          if (drop) begin
            state_n = S_REQ;
            drop_n  = 1'b0;
          end else begin
            instr_n = im_rdata;
            state_n = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // Redirect takes priority over a consume in the same cycle.
        if (redirect_valid) begin
          fetch_pc_n = redir_target;
          state_n    = S_REQ;
        end else if (IFID_write) begin
          fetch_pc_n = fetch_pc + 32'd4;
          state_n    = S_REQ;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State registers; im_req/im_addr are registered from next-state values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      instr_q  <= 32'h0000_0000;
      drop     <= 1'b0;
      im_req   <= 1'b0;
      im_addr  <= RESET_PC;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      instr_q  <= instr_n;
      drop     <= drop_n;
      im_req   <= (state_n == S_REQ);
      im_addr  <= fetch_pc_n;
    end
  end

  // Without a held word the IF/ID register sees a bubble at the fetch PC.
  always_comb begin
    if_valid    = (state == S_HOLD);
    instruction = if_valid ? instr_q : 32'h0000_0000;
    pc          = fetch_pc;
    IFID_flush  = redirect_valid;
    fsm_state   = state;
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios followed by a randomized
// memory responder, all checked every cycle against a transaction-level model.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        IFID_write, redirect_valid;
  logic [31:0] redirect_pc;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ready, im_rvalid;
  logic [31:0] im_rdata;
  logic [31:0] instruction, pc;
  logic        if_valid, IFID_flush;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];

  if_fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(rst_n), .IFID_write(IFID_write),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .im_req(im_req), .im_addr(im_addr), .im_ready(im_ready),
    .im_rvalid(im_rvalid), .im_rdata(im_rdata),
    .instruction(instruction), .pc(pc), .if_valid(if_valid),
    .IFID_flush(IFID_flush), .fsm_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Transaction-level reference model: what fetch address is current, whether
  // a request is outstanding (and still wanted), and whether a word is held.
  logic        m_idle = 1'b1, m_out = 1'b0, m_live = 1'b0, m_have = 1'b0;
  logic [31:0] m_pc = RESET_PC, m_word = 32'h0;
  logic        m_req_exp;

  always @(negedge clk) begin
    logic accept, consume;
    if (!rst_n) begin
      m_idle = 1'b1; m_out = 1'b0; m_live = 1'b0; m_have = 1'b0; m_pc = RESET_PC;
    end
    m_req_exp = !m_idle && !m_have && !m_out;
    check_eq("if_valid", {31'b0, if_valid}, {31'b0, m_have});
    check_eq("pc", pc, m_pc);
    check_eq("instruction", instruction, m_have ? m_word : 32'h0);
    check_eq("im_req", {31'b0, im_req}, {31'b0, m_req_exp});
    if (m_req_exp) check_eq("im_addr", im_addr, m_pc);
    check_eq("IFID_flush", {31'b0, IFID_flush}, {31'b0, redirect_valid});
    if (rst_n) begin
      // Advance the model to what must hold after the coming rising edge.
      accept  = m_req_exp && im_ready;
      consume = m_have && IFID_write && !redirect_valid;
      if (im_rvalid && (m_out || accept)) begin
        if (!redirect_valid && (!m_out || m_live)) begin
          m_have = 1'b1;
          m_word = im_rdata;
        end
        m_out = 1'b0;
      end else if (accept) begin
        m_out  = 1'b1;
        m_live = !redirect_valid;
      end else if (m_out && redirect_valid) begin
        m_live = 1'b0;
      end
      if (redirect_valid) begin
        m_pc   = redirect_pc & 32'hFFFF_FFFC;
        m_have = 1'b0;
      end else if (consume) begin
        m_have = 1'b0;
        m_pc   = m_pc + 32'd4;
      end
      m_idle = 1'b0;
    end
  end

  // Driver: apply one cycle of inputs, return 1 time unit after the edge.
  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rd,
                       input logic wr, input logic redir, input logic [31:0] rpc);
    im_ready = rdy; im_rvalid = rv; im_rdata = rd;
    IFID_write = wr; redirect_valid = redir; redirect_pc = rpc;
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  // Wait (bounded) for a request, check its address, accept it, answer next cycle.
  task automatic serve(input logic [31:0] exp_addr, input logic [31:0] data);
    int n = 0;
    while (!im_req && n < 20) begin
      idle_cycle();
      n++;
    end
    check_eq("serve_req_seen", {31'b0, im_req}, 32'd1);
    check_eq("serve_addr", im_addr, exp_addr);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, data, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] w, e;
    logic        pend;
    logic [2:0]  pend_dly;
    logic [31:0] pend_addr;
    logic        rdy, rv;
    logic [31:0] rd;

    rst_n = 1'b0;
    im_ready = 0; im_rvalid = 0; im_rdata = 0;
    IFID_write = 0; redirect_valid = 0; redirect_pc = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset release and first fetch
    check_eq("idle_no_req", {31'b0, im_req}, 32'd0);
    idle_cycle();
    serve(32'h0, 32'h0000_0013);
    check_eq("first_instr", instruction, 32'h0000_0013);
    check_eq("first_pc", pc, 32'h0);
    check_eq("first_valid", {31'b0, if_valid}, 32'd1);

    // Back-to-back consumes at 0, 4, 8
    exp_q.push_back(32'h0);
    for (int i = 1; i <= 3; i++) begin
      e = exp_q.pop_front();
      check_eq("consume_pc", pc, e);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      serve(32'(4 * i), mem_word(32'(4 * i)));
      exp_q.push_back(32'(4 * i));
    end
    e = exp_q.pop_front();
    check_eq("consume_pc_last", pc, e);
    check_eq("consume_instr_last", instruction, mem_word(32'd12));

    // Redirect during WAIT; late response dropped
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_eq("req_16", im_addr, 32'd16);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    im_ready = 0; redirect_valid = 1; redirect_pc = 32'h0000_0102; IFID_write = 0;
    #1;
    check_eq("flush_on_redirect", {31'b0, IFID_flush}, 32'd1);
    @(posedge clk); #1;
    idle_cycle();
    drive(1'b0, 1'b1, 32'hBAD0_0001, 1'b0, 1'b0, 32'h0);
    check_eq("drop_not_valid", {31'b0, if_valid}, 32'd0);
    check_eq("redir_addr", im_addr, 32'h0000_0100);
    check_eq("redir_req", {31'b0, im_req}, 32'd1);

    // Redirect in REQ before acceptance, then redirect+consume in HOLD
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0040);
    serve(32'h40, mem_word(32'h40));
    check_eq("hold_pc_40", pc, 32'h40);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0200);
    check_eq("redir_wins_addr", im_addr, 32'h200);
    check_eq("redir_wins_valid", {31'b0, if_valid}, 32'd0);

    // Stall in HOLD for 5 cycles
    w = 32'hCAFE_0200;
    serve(32'h200, w);
    repeat (5) begin
      check_eq("stall_instr", instruction, w);
      check_eq("stall_pc", pc, 32'h200);
      check_eq("stall_no_req", {31'b0, im_req}, 32'd0);
      idle_cycle();
    end

    // PC wrap (unaligned redirect target is forced to word alignment)
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    serve(32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC));
    check_eq("wrap_pc", pc, 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_eq("wrap_addr", im_addr, 32'h0);

    // Reset pulse in WAIT, late response ignored
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0080);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    check_eq("rst_valid", {31'b0, if_valid}, 32'd0);
    check_eq("rst_instr", instruction, 32'h0);
    check_eq("rst_pc", pc, RESET_PC);
    check_eq("rst_req", {31'b0, im_req}, 32'd0);
    check_eq("rst_addr", im_addr, RESET_PC);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    check_eq("late_rvalid_ignored", {31'b0, if_valid}, 32'd0);
    check_eq("post_rst_addr", im_addr, RESET_PC);
    serve(RESET_PC, mem_word(RESET_PC));

    // Randomized phase
    pend = 1'b0; pend_dly = 3'd0; pend_addr = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      rdy = 1'b0; rv = 1'b0; rd = 32'h0;
      if (pend) begin
        if (pend_dly == 3'd0) begin
          rv = 1'b1; rd = mem_word(pend_addr); pend = 1'b0;
        end else begin
          pend_dly = pend_dly - 3'd1;
        end
      end else if (im_req) begin
        rdy = ($urandom_range(0, 2) != 0);
        if (rdy) begin
          if ($urandom_range(0, 3) == 0) begin
            rv = 1'b1; rd = mem_word(im_addr);
          end else begin
            pend = 1'b1; pend_dly = 3'($urandom_range(0, 3)); pend_addr = im_addr;
          end
        end
      end
      drive(rdy, rv, rd, 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0), $urandom());
    end
    idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have ports, one per line: name  direction  width  meaning.
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- IFID_write  input  1  downstream IF/ID register captures this cycle
- redirect_valid  input  1  branch/jump resolved taken, single-cycle pulse
- redirect_pc  input  32  redirect target
- im_req  output  1  instruction-memory request valid
- im_addr  output  32  request address
- im_ready  input  1  memory accepts request this cycle
- im_rvalid  input  1  read data valid
- im_rdata  input  32  read data
- instruction  output  32  fetched word to IF/ID
- pc  output  32  address of instruction
- if_valid  output  1  instruction/pc hold a real fetched word
- IFID_flush  output  1  squash request to IF/ID

Function
REQ-003 SHALL implement a four-state FSM: IDLE, REQ, WAIT, HOLD.
REQ-004 SHALL move from IDLE to REQ on the first clock after reset deasserts; im_req low in IDLE.
REQ-005 In REQ, im_req SHALL be 1 and im_addr SHALL equal the fetch PC; on im_ready=1, go to WAIT.
REQ-006 In WAIT, on im_rvalid=1, capture im_rdata and fetch PC into the output register and go to HOLD.
REQ-007 SHALL accept im_rvalid in the same cycle as im_ready; responses are in order, at most one outstanding.
REQ-008 In HOLD, if_valid SHALL be 1; on IFID_write=1, fetch PC advances by 4 and state goes to REQ (earliest re-request 1 cycle after consume).
REQ-009 With if_valid=0, instruction SHALL read 32'h0000_0000 and pc SHALL read the current fetch PC, so IF/ID captures a bubble.
REQ-010 PC increment SHALL be modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0).
REQ-011 redirect_pc[1:0] SHALL be forced to 2'b00 when loaded.
REQ-012 Redirect in REQ before acceptance: fetch PC := redirect_pc; im_addr changes that cycle's next edge; stay in REQ.
REQ-013 Redirect in REQ coincident with im_ready=1: request is treated as accepted; the response SHALL be discarded.
REQ-014 Redirect in WAIT: set drop flag; the next im_rvalid SHALL be discarded, then go to REQ with redirect_pc; if im_rvalid arrives same cycle as redirect, that data SHALL be discarded.
REQ-015 Redirect in HOLD: held word discarded, if_valid=0 next cycle, go to REQ with redirect_pc; redirect wins over simultaneous IFID_write.
REQ-016 IFID_flush SHALL equal redirect_valid combinationally, so the IF/ID register squashes the wrong-path word in the same cycle.
REQ-017 Redirect in IDLE SHALL load fetch PC; the first request uses redirect_pc.
REQ-018 IFID_write while if_valid=0 SHALL NOT advance the PC.
REQ-019 im_addr and im_req SHALL be registered outputs, glitch-free.

Reset
REQ-020 While reset=0: state IDLE, fetch PC=RESET_PC, im_req=0, if_valid=0, instruction=0, pc=RESET_PC, drop flag=0.
REQ-021 Reset asserted mid-WAIT SHALL abandon the outstanding request; a late im_rvalid after release while in IDLE/REQ SHALL be ignored.

Verification
REQ-022 Bench SHALL cover:
- Reset release, im_ready=1 immediately, im_rvalid 1 cycle later with 32'h00000013 -> im_addr=0, HOLD with instruction=32'h00000013, pc=0.
- Three back-to-back consumes, IFID_write=1 -> fetch addresses 0,4,8, each pc matches its word.
- Redirect to 32'h0000_0102 during WAIT, rvalid 2 cycles later -> data dropped, next im_addr=32'h0000_0100, IFID_flush=1 for that cycle.
- Redirect and IFID_write together in HOLD at pc=32'h40 -> next im_addr=redirect target, not 32'h44.
- IFID_write=0 for 5 cycles in HOLD -> instruction and pc stable, im_req=0.
- PC at 32'hFFFF_FFFC consumed -> next im_addr=32'h0; reset pulse in WAIT -> outputs at reset values.
